// File: rtl/receiver_block_packetizer.sv
// ----------------------------------------------------------------------------
// receiver_block_packetizer
//
// Reads decoded blocks out of the single-receiver manager's block RAM and
// packs them into a checksummed byte frame on a valid/ready byte stream:
//
//   HEADER_BYTE, N, N x {7'b0,word[16]}, word[15:8], word[7:0],
//                        ts[23:16], ts[15:8], ts[7:0], CHECKSUM
//
// The checksum is the XOR of the count byte and every block byte (the header
// byte is excluded). A block whose read never completes within TIMEOUT cycles
// is replaced by an all-zero block and flags the sticky timeout_err.
//
// Ports:
//   clk_96MHz           in   system clock
//   reset               in   synchronous, active-high reset
//   avl_blocks_nb[7:0]  in   number of blocks currently stored in RAM
//   block_wanted[40:0]  in   RAM read data: [40:24] decoded word, [23:0] timestamp
//   data_ready          in   block_wanted valid for block_wanted_number
//   block_wanted_number out  RAM read index
//   byte_out[7:0]       out  stream byte
//   byte_valid          out  byte_out valid
//   byte_ready          in   sink accepts when byte_valid && byte_ready
//   frame_busy          out  high from frame start until the last byte is taken
//   timeout_err         out  sticky block-timeout flag, cleared by reset only
// ----------------------------------------------------------------------------
module receiver_block_packetizer #(
    parameter int          MIN_BLOCKS  = 1,
    parameter int          MAX_BLOCKS  = 16,
    parameter int          TIMEOUT     = 1024,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
    input  logic        clk_96MHz,
    input  logic        reset,
    input  logic [7:0]  avl_blocks_nb,
    input  logic [40:0] block_wanted,
    input  logic        data_ready,
    output logic [7:0]  block_wanted_number,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        frame_busy,
    output logic        timeout_err
);

    localparam int               TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]       MIN_B    = 8'(MIN_BLOCKS);
    localparam logic [7:0]       MAX_B    = 8'(MAX_BLOCKS);

    typedef enum logic [2:0] {
        IDLE, HEADER, COUNT, REQ, WAIT, SEND, CHECKSUM, DONE
    } state_t;

    state_t        state_q;
    logic [7:0]    n_q;
    logic [7:0]    idx_q;
    logic [2:0]    bcnt_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    cs_q;
    logic [7:0]    byte_out_q;
    logic          byte_valid_q;
    logic          frame_busy_q;
    logic          timeout_err_q;
    logic [7:0]    bwn_q;
    logic [40:0]   hold_q;

    logic          accept;
    logic          wait_done;
    logic [40:0]   blk_in;

    // Byte k (0..5) of a block in transmit order; the 17-bit word is
    // left-padded to 24 bits so every byte lands on a byte boundary.
    function automatic logic [7:0] block_byte(input logic [40:0] blk, input logic [2:0] k);
        logic [47:0] padded;
        padded = {7'b0, blk};
        case (k)
            3'd0:    return padded[47:40];
            3'd1:    return padded[39:32];
            3'd2:    return padded[31:24];
            3'd3:    return padded[23:16];
            3'd4:    return padded[15:8];
            default: return padded[7:0];
        endcase
    endfunction

    assign accept    = byte_valid_q && byte_ready;
    assign wait_done = (state_q == WAIT) && (data_ready || (tmo_q == TMO_LAST));
    // A timed-out read substitutes an all-zero block.
    assign blk_in    = data_ready ? block_wanted : 41'd0;

    // Block holding register: pure data, loaded once per block.
    always_ff @(posedge clk_96MHz) begin
        if (wait_done) begin
            hold_q <= blk_in;
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            state_q       <= IDLE;
            n_q           <= 8'd0;
            idx_q         <= 8'd0;
            bcnt_q        <= 3'd0;
            tmo_q         <= '0;
            cs_q          <= 8'd0;
            byte_out_q    <= 8'd0;
            byte_valid_q  <= 1'b0;
            frame_busy_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            bwn_q         <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (avl_blocks_nb >= MIN_B) begin
                        n_q          <= (avl_blocks_nb > MAX_B) ? MAX_B : avl_blocks_nb;
                        cs_q         <= 8'd0;
                        idx_q        <= 8'd0;
                        bwn_q        <= 8'd0;
                        frame_busy_q <= 1'b1;
                        byte_out_q   <= HEADER_BYTE;
                        byte_valid_q <= 1'b1;
                        state_q      <= HEADER;
                    end
                end
                HEADER: begin
                    if (accept) begin
                        byte_out_q <= n_q;
                        state_q    <= COUNT;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        cs_q         <= cs_q ^ n_q;
                        byte_valid_q <= 1'b0;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    // The read index was already updated on entry to REQ, so
                    // whatever data_ready shows in this cycle belongs to the
                    // previous index and is deliberately not sampled.
                    tmo_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (wait_done) begin
                        if (!data_ready) begin
                            timeout_err_q <= 1'b1;
                        end
                        byte_out_q   <= block_byte(blk_in, 3'd0);
                        byte_valid_q <= 1'b1;
                        bcnt_q       <= 3'd0;
                        state_q      <= SEND;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                SEND: begin
                    if (accept) begin
                        cs_q <= cs_q ^ byte_out_q;
                        if (bcnt_q == 3'd5) begin
                            if (idx_q == n_q - 8'd1) begin
                                byte_out_q <= cs_q ^ byte_out_q;
                                state_q    <= CHECKSUM;
                            end else begin
                                idx_q        <= idx_q + 8'd1;
                                bwn_q        <= idx_q + 8'd1;
                                byte_valid_q <= 1'b0;
                                state_q      <= REQ;
                            end
                        end else begin
                            bcnt_q     <= bcnt_q + 3'd1;
                            byte_out_q <= block_byte(hold_q, bcnt_q + 3'd1);
                        end
                    end
                end
                CHECKSUM: begin
                    if (accept) begin
                        byte_valid_q <= 1'b0;
                        frame_busy_q <= 1'b0;
                        bwn_q        <= 8'd0;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign block_wanted_number = bwn_q;
    assign byte_out            = byte_out_q;
    assign byte_valid          = byte_valid_q;
    assign frame_busy          = frame_busy_q;
    assign timeout_err         = timeout_err_q;

endmodule
